// File: rtl/clken_pkg.sv
// Shared constants and types for the clock-enable generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clken_pkg;

    localparam int CLKEN_MAX_CH = 8;   // upper bound on channel count
    localparam int CH_IDX_W     = 3;   // width of a channel index on the cfg bus
    localparam int CLKEN_CNT_W  = 24;  // default counter/divisor width

    typedef logic [CLKEN_CNT_W-1:0] div_t;

    // Named reset divisors for the standard channel set (100 MHz master clock)
    localparam div_t DIV_PIX  = div_t'(4);        // 25 MHz pixel enable
    localparam div_t DIV_SEG  = div_t'(262144);   // 7-seg digit scan
    localparam div_t DIV_GAME = div_t'(2000000);  // 50 Hz game tick

endpackage

// File: rtl/clken_if.sv
// Divisor-write configuration bus: valid/ready handshake plus sticky error flag.
// Latency: n/a (wires only).
// Backpressure: cfg_ready low while a divisor write is still pending.
// Ports: cfg_valid/cfg_ch/cfg_div from master, cfg_ready/cfg_err from slave.
interface clken_if
    import clken_pkg::*;
#(
    parameter int CNT_W = CLKEN_CNT_W
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic                cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clken_channel.sv
// One enable channel: free-running modulo-div counter with a registered 1-cycle tick.
// Latency: tick is high the cycle after cnt reaches its wrap value.
// Backpressure: none; divisor updates only land on the apply strobe (wrap or sync).
// Ports: clk, clr, run, sync, apply/new_div in; wrap (comb), tick, and sq_out when
// CLKEN_SQUARE_EN is defined.
module clken_channel #(
    parameter int               CNT_W    = 24,
    parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             sync,
    input  logic             apply,
    input  logic [CNT_W-1:0] new_div,
    output logic             wrap,
    output logic             tick
`ifdef CLKEN_SQUARE_EN
    ,
    output logic             sq_out
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;

    // Divisors 0 and 1 both collapse to a wrap on every cycle.
    assign last = (div < CNT_W'(2)) ? '0 : div - CNT_W'(1);

    // sync overrides the wrap so the top never sees a wrap and a sync apply together.
    assign wrap = run & ~sync & (cnt == last);

    always_comb begin
        cnt_nxt = cnt;
        if (sync) begin
            cnt_nxt = '0;
        end else if (run) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    // apply is only raised by the top on wrap or sync, both of which restart cnt.
    assign div_nxt = apply ? new_div : div;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt  <= '0;
            div  <= DIV_INIT;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            div  <= div_nxt;
            tick <= wrap;
        end
    end

`ifdef CLKEN_SQUARE_EN
    logic [CNT_W-1:0] half_nxt;

    // ceil(div/2) without the overflow of (div+1)>>1
    assign half_nxt = (div_nxt >> 1) + CNT_W'(div_nxt[0]);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sq_out <= 1'b0;
        end else if (sync) begin
            sq_out <= 1'b0;
        end else if (run) begin
            sq_out <= (cnt_nxt < half_nxt);
        end
    end
`endif

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator with runtime-reprogrammable divisors.
// Latency: first tick div cycles after clr; divisor writes take effect at the next wrap or sync.
// Backpressure: cfg_ready low from the cycle after an accepted write until the cycle after it applies.
// Ports: clk, clr, run, sync, cfg (clken_if.slave), tick[NUM_CH]; sq_out[NUM_CH] with CLKEN_SQUARE_EN.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = CLKEN_CNT_W,
    parameter logic [CNT_W*NUM_CH-1:0] DIV_INIT = {DIV_GAME, DIV_SEG, DIV_PIX}
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              sync,
    clken_if.slave            cfg,
    output logic [NUM_CH-1:0] tick
`ifdef CLKEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] sq_out
`endif
);

    logic                pend_vld;
    logic [CH_IDX_W-1:0] pend_ch;
    logic [CNT_W-1:0]    pend_div;
    logic                err_q;
    logic                xfer;
    logic                ch_bad;
    logic [NUM_CH-1:0]   wrap;
    logic [NUM_CH-1:0]   apply;

    // Only one write may be outstanding; ready is simply "nothing pending".
    assign cfg.cfg_ready = ~pend_vld;
    assign cfg.cfg_err   = err_q;
    assign xfer          = cfg.cfg_valid & ~pend_vld;
    assign ch_bad        = {1'b0, cfg.cfg_ch} >= (CH_IDX_W + 1)'(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply[i] = pend_vld & (pend_ch == CH_IDX_W'(i)) & (wrap[i] | sync);

        clken_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk),
            .clr     (clr),
            .run     (run),
            .sync    (sync),
            .apply   (apply[i]),
            .new_div (pend_div),
            .wrap    (wrap[i]),
            .tick    (tick[i])
`ifdef CLKEN_SQUARE_EN
            ,
            .sq_out  (sq_out[i])
`endif
        );
    end

    // A transfer only happens with nothing pending and an apply only with something
    // pending, so the two branches never compete in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend_vld <= 1'b0;
            pend_ch  <= '0;
            pend_div <= '0;
            err_q    <= 1'b0;
        end else begin
            if (xfer && !ch_bad) begin
                pend_vld <= 1'b1;
                pend_ch  <= cfg.cfg_ch;
                pend_div <= cfg.cfg_div;
            end else if (|apply) begin
                pend_vld <= 1'b0;
            end
            if (xfer && ch_bad) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clken_gen.sv
module tb_clken_gen;
    import clken_pkg::*;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 24;

    logic clk = 1'b0;
    logic clr;
    logic run;
    logic sync;
    logic [NUM_CH-1:0] tick;
`ifdef CLKEN_SQUARE_EN
    logic [NUM_CH-1:0] sq_out;
`endif

    clken_if #(.CNT_W(CNT_W)) cfg_bus ();

    clken_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .clr    (clr),
        .run    (run),
        .sync   (sync),
        .cfg    (cfg_bus),
        .tick   (tick)
`ifdef CLKEN_SQUARE_EN
        ,
        .sq_out (sq_out)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel counts down the run cycles left until its next tick.
    int m_div  [NUM_CH];
    int m_left [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_sqz  [NUM_CH];
    bit m_pv;
    int m_pch;
    int m_pdiv;
    bit m_err;

    function automatic int deff(input int d);
        return (d < 2) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_div[0] = 4;
        m_div[1] = 262144;
        m_div[2] = 2000000;
        for (int i = 0; i < NUM_CH; i++) begin
            m_left[i] = deff(m_div[i]);
            m_tick[i] = 1'b0;
            m_sqz[i]  = 1'b1;
        end
        m_pv  = 1'b0;
        m_pch = 0;
        m_pdiv = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v, input int ch, input int dv);
        bit applied = 1'b0;
        bit xf;
        for (int i = 0; i < NUM_CH; i++) begin
            bit ap = m_pv && (m_pch == i);
            if (s) begin
                m_tick[i] = 1'b0;
                if (ap) begin m_div[i] = m_pdiv; applied = 1'b1; end
                m_left[i] = deff(m_div[i]);
                m_sqz[i]  = 1'b1;
            end else if (r) begin
                m_sqz[i] = 1'b0;
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    if (ap) begin m_div[i] = m_pdiv; applied = 1'b1; end
                    m_left[i] = deff(m_div[i]);
                end else begin
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
        end
        xf = v && !m_pv;
        if (applied) m_pv = 1'b0;
        if (xf) begin
            if (ch < NUM_CH) begin
                m_pv = 1'b1; m_pch = ch; m_pdiv = dv;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] et;
        for (int i = 0; i < NUM_CH; i++) et[i] = m_tick[i];
        chk("tick", 32'(tick), 32'(et));
        chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(!m_pv));
        chk("cfg_err", 32'(cfg_bus.cfg_err), 32'(m_err));
`ifdef CLKEN_SQUARE_EN
        begin
            logic [NUM_CH-1:0] es;
            for (int i = 0; i < NUM_CH; i++) begin
                int c = deff(m_div[i]) - m_left[i];
                es[i] = !m_sqz[i] && (c < (m_div[i] + 1) / 2);
            end
            chk("sq_out", 32'(sq_out), 32'(es));
        end
`endif
    endtask

    // mode 0: run only; mode 1: random incl. bad channels; mode 2: random, valid channels
    task automatic run_cycles(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            bit r = 1'b1, s = 1'b0, v = 1'b0;
            int ch = 0, dv = 0;
            if (mode != 0) begin
                r  = ($urandom_range(0, 9) != 0);
                s  = ($urandom_range(0, 49) == 0);
                v  = ($urandom_range(0, 7) == 0);
                ch = (mode == 1) ? $urandom_range(0, 5) : $urandom_range(0, NUM_CH - 1);
                dv = $urandom_range(0, 12);
            end
            run  = r;
            sync = s;
            cfg_bus.cfg_valid = v;
            cfg_bus.cfg_ch    = 3'(ch);
            cfg_bus.cfg_div   = 24'(dv);
            model_step(r, s, v, ch, dv);
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic idle_inputs();
        run  = 1'b0;
        sync = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_div   = '0;
    endtask

    initial begin
        clr = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        clr = 1'b0;

        run_cycles(1000, 0);
        run_cycles(3000, 1);

        // Asynchronous clear in the middle of operation
        clr = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        clr = 1'b0;

        run_cycles(200, 0);
        run_cycles(2000, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
